// File: rtl/odd_width_split_if.sv
// Stream bundle between a wide-word source and a narrow-element consumer.
// The unpacker is the slave: it receives wr_* and produces rd_*.
interface odd_width_split_if #(
    parameter int IN_SIZE  = 16,
    parameter int OUT_SIZE = 12
);
    // Each side: a beat transfers on a clock edge where valid & ready are both high;
    // a source holds data/last stable while valid & !ready, a sink may move ready freely.
    logic [IN_SIZE-1:0]  wr_data;
    logic                wr_vld;
    logic                wr_ready;
    logic                wr_last;
    logic [OUT_SIZE-1:0] rd_data;
    logic                rd_vld;
    logic                rd_ready;
    logic                rd_last;

    modport slave (
        input  wr_data, wr_vld, wr_last, rd_ready,
        output wr_ready, rd_data, rd_vld, rd_last
    );

    modport master (
        output wr_data, wr_vld, wr_last, rd_ready,
        input  wr_ready, rd_data, rd_vld, rd_last
    );
endinterface

// File: rtl/odd_width_split.sv
// Unpacks an MSB-first stream of IN_SIZE-bit words into OUT_SIZE-bit elements using an
// MSB-aligned bit buffer; packet residue shorter than one element is dropped at rd_last.
module odd_width_split #(
    parameter int IN_SIZE  = 16,
    parameter int OUT_SIZE = 12
) (
    input  logic                                clock,
    input  logic                                rst_n,
    odd_width_split_if.slave                    bus,
    output logic [$clog2(IN_SIZE+OUT_SIZE)-1:0] o_dbg_cnt,
    output logic                                o_dbg_last_pend
);
    localparam int BUF_W = IN_SIZE + OUT_SIZE - 1;
    localparam int CNT_W = $clog2(BUF_W + 1);
    localparam logic [CNT_W-1:0] OUT_C  = CNT_W'(OUT_SIZE);
    localparam logic [CNT_W-1:0] OUT2_C = CNT_W'(2 * OUT_SIZE);
    localparam logic [CNT_W-1:0] IN_C   = CNT_W'(IN_SIZE);

    generate
        if (IN_SIZE <= OUT_SIZE) begin : g_param_check
            $error("odd_width_split: IN_SIZE must be greater than OUT_SIZE");
        end
    endgenerate

    logic [BUF_W-1:0] r_buf;
    logic [CNT_W-1:0] r_cnt;
    logic             r_last_pend;

    logic             w_rd_vld;
    logic             w_rd_last;
    logic             w_wr_ready;
    logic             w_fire_i;
    logic             w_fire_o;
    logic [CNT_W-1:0] w_cnt_sh;
    logic [BUF_W-1:0] w_buf_sh;
    logic [BUF_W-1:0] w_ins;

    // Shift out the element being read first, then land the new word right below
    // the bits still held; wr_ready keeps that offset within the buffer.
    always_comb begin
        w_rd_vld   = (r_cnt >= OUT_C);
        w_rd_last  = r_last_pend & w_rd_vld & (r_cnt < OUT2_C);
        w_wr_ready = !r_last_pend & ((r_cnt < OUT_C) | (bus.rd_ready & (r_cnt < OUT2_C)));
        w_fire_o   = w_rd_vld & bus.rd_ready;
        w_fire_i   = bus.wr_vld & w_wr_ready;
        w_cnt_sh   = r_cnt;
        w_buf_sh   = r_buf;
        if (w_fire_o) begin
            w_cnt_sh = r_cnt - OUT_C;
            w_buf_sh = r_buf << OUT_SIZE;
        end
        w_ins = {bus.wr_data, {(BUF_W-IN_SIZE){1'b0}}} >> w_cnt_sh;
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_buf       <= '0;
            r_cnt       <= '0;
            r_last_pend <= 1'b0;
        end else if (w_fire_o & w_rd_last) begin
            r_buf       <= '0;
            r_cnt       <= '0;
            r_last_pend <= 1'b0;
        end else begin
            r_buf <= w_fire_i ? (w_buf_sh | w_ins) : w_buf_sh;
            r_cnt <= w_fire_i ? (w_cnt_sh + IN_C) : w_cnt_sh;
            if (w_fire_i & bus.wr_last) begin
                r_last_pend <= 1'b1;
            end
        end
    end

    assign bus.rd_vld      = w_rd_vld;
    assign bus.rd_last     = w_rd_last;
    assign bus.rd_data     = r_buf[BUF_W-1 -: OUT_SIZE];
    assign bus.wr_ready    = w_wr_ready;
    assign o_dbg_cnt       = r_cnt;
    assign o_dbg_last_pend = r_last_pend;
endmodule

// File: tb/tb_odd_width_split.sv
// Bench for odd_width_split (16 -> 12): a bit-queue reference model checked every cycle,
// plus directed known-answer packets and randomized packets with random backpressure.
module tb_odd_width_split;
    logic       clock;
    logic       rst_n;
    logic [4:0] dbg_cnt;
    logic       dbg_lp;

    int total = 0;
    int bad   = 0;

    odd_width_split_if #(.IN_SIZE(16), .OUT_SIZE(12)) bus ();

    odd_width_split #(.IN_SIZE(16), .OUT_SIZE(12)) dut (
        .clock          (clock),
        .rst_n          (rst_n),
        .bus            (bus),
        .o_dbg_cnt      (dbg_cnt),
        .o_dbg_last_pend(dbg_lp)
    );

    // clock / reset
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // reference model: pending bits as a plain bit queue, complete elements as {last,data}
    bit          bitq[$];
    logic [12:0] exp_q[$];
    logic [12:0] rx_log[$];
    int          pad_bits = 0;
    bit          rand_rdy = 0;

    int          m_cnt;
    bit          m_vld, m_lp, m_wr_rdy;
    logic [11:0] m_e;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clock) begin
        if (!rst_n) begin
            bitq.delete();
            exp_q.delete();
            pad_bits = 0;
        end else begin
            m_cnt    = 12 * exp_q.size() + bitq.size() + pad_bits;
            m_vld    = (exp_q.size() != 0);
            m_lp     = m_vld && exp_q[exp_q.size()-1][12];
            m_wr_rdy = !m_lp && (m_cnt < 12 || (bus.rd_ready && m_cnt < 24));
            check("rd_vld", bus.rd_vld, m_vld);
            check("wr_ready", bus.wr_ready, m_wr_rdy);
            check("cnt", dbg_cnt, m_cnt);
            check("last_pend", dbg_lp, m_lp);
            if (m_vld) begin
                check("rd_data", bus.rd_data, exp_q[0][11:0]);
                check("rd_last", bus.rd_last, exp_q[0][12]);
                if (bus.rd_ready) begin
                    rx_log.push_back({bus.rd_last, bus.rd_data});
                    if (exp_q[0][12]) pad_bits = 0;
                    void'(exp_q.pop_front());
                end
            end
            if (m_wr_rdy && bus.wr_vld) begin
                for (int b = 15; b >= 0; b--) bitq.push_back(bus.wr_data[b]);
                while (bitq.size() >= 12) begin
                    m_e = '0;
                    for (int j = 0; j < 12; j++) m_e = {m_e[10:0], bitq.pop_front()};
                    exp_q.push_back({1'b0, m_e});
                end
                if (bus.wr_last) begin
                    exp_q[exp_q.size()-1][12] = 1'b1;
                    pad_bits = bitq.size();
                    bitq.delete();
                end
            end
        end
    end

    // driver tasks
    task automatic send(input logic [15:0] d, input logic l);
        bit acc;
        acc = 0;
        bus.wr_data = d;
        bus.wr_last = l;
        bus.wr_vld  = 1'b1;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clock);
            acc = bus.wr_ready;
            @(posedge clock);
            #1;
            if (rand_rdy) bus.rd_ready = 1'($urandom_range(0, 1));
        end
        bus.wr_vld = 1'b0;
        check("send_accept", acc, 1);
    endtask

    task automatic wait_idle(input int max_cyc);
        bit done;
        done = 0;
        for (int i = 0; i < max_cyc && !done; i++) begin
            @(posedge clock);
            #1;
            if (rand_rdy) bus.rd_ready = 1'($urandom_range(0, 1));
            done = (exp_q.size() == 0);
        end
        check("drain", done, 1);
    endtask

    logic [479:0] stream;
    logic [15:0]  swords[30];
    logic [15:0]  w0, w1, w2;
    logic [47:0]  cat;
    logic [11:0]  hold;
    int           idx;
    int           exp_elems;
    int           len;
    bit           acc;

    initial begin
        rst_n       = 1'b0;
        bus.wr_data = '0;
        bus.wr_vld  = 1'b0;
        bus.wr_last = 1'b0;
        bus.rd_ready = 1'b0;
        #3;
        check("rst_rd_vld", bus.rd_vld, 0);
        check("rst_rd_last", bus.rd_last, 0);
        check("rst_rd_data", bus.rd_data, 0);
        check("rst_wr_ready", bus.wr_ready, 1);
        check("rst_cnt", dbg_cnt, 0);
        @(posedge clock);
        @(posedge clock);
        #1;
        rst_n = 1'b1;

        // 1: known-answer packet
        bus.rd_ready = 1'b1;
        rx_log.delete();
        send(16'hABC1, 0);
        send(16'h23DE, 0);
        send(16'hF456, 1);
        wait_idle(50);
        check("t1_n", rx_log.size(), 4);
        if (rx_log.size() == 4) begin
            check("t1_e0", rx_log[0], 13'h0ABC);
            check("t1_e1", rx_log[1], 13'h0123);
            check("t1_e2", rx_log[2], 13'h0DEF);
            check("t1_e3", rx_log[3], 13'h1456);
        end
        check("t1_cnt", dbg_cnt, 0);

        // 2: residual pad dropped
        rx_log.delete();
        send(16'hABC1, 0);
        send(16'h2300, 1);
        wait_idle(50);
        check("t2_n", rx_log.size(), 2);
        if (rx_log.size() == 2) begin
            check("t2_e0", rx_log[0], 13'h0ABC);
            check("t2_e1", rx_log[1], 13'h1123);
        end
        check("t2_cnt", dbg_cnt, 0);
        check("t2_wr_ready", bus.wr_ready, 1);

        // 3: continuous streaming of an incrementing 12-bit pattern
        for (int k = 0; k < 40; k++) stream[479-12*k -: 12] = 12'h100 + 12'(k);
        for (int w = 0; w < 30; w++) swords[w] = stream[479-16*w -: 16];
        rx_log.delete();
        idx = 0;
        bus.wr_vld = 1'b1;
        for (int cyc = 0; cyc < 60 && idx < 30; cyc++) begin
            bus.wr_data = swords[idx];
            bus.wr_last = (idx == 29);
            @(negedge clock);
            check("t3_wr_ready", bus.wr_ready, (cyc % 4) != 3);
            if (cyc >= 1) check("t3_rd_vld", bus.rd_vld, 1);
            acc = bus.wr_ready;
            @(posedge clock);
            #1;
            if (acc) idx++;
        end
        bus.wr_vld = 1'b0;
        check("t3_words", idx, 30);
        wait_idle(50);
        check("t3_n", rx_log.size(), 40);
        if (rx_log.size() == 40) begin
            for (int k = 0; k < 40; k++)
                check("t3_elem", rx_log[k], {k == 39, 12'h100 + 12'(k)});
        end

        // 4: backpressure mid-packet
        w0 = 16'($urandom);
        w1 = 16'($urandom);
        w2 = 16'($urandom);
        cat = {w0, w1, w2};
        rx_log.delete();
        bus.rd_ready = 1'b0;
        send(w0, 0);
        hold = w0[15:4];
        bus.wr_data = w1;
        bus.wr_last = 1'b0;
        bus.wr_vld  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("t4_hold_data", bus.rd_data, hold);
            check("t4_hold_last", bus.rd_last, 0);
            check("t4_wr_blocked", bus.wr_ready, 0);
            @(posedge clock);
            #1;
        end
        bus.rd_ready = 1'b1;
        send(w1, 0);
        send(w2, 1);
        wait_idle(50);
        check("t4_n", rx_log.size(), 4);
        if (rx_log.size() == 4) begin
            for (int k = 0; k < 4; k++)
                check("t4_elem", rx_log[k], {k == 3, cat[47-12*k -: 12]});
        end

        // 5: back-to-back packets, B offered right after A's last
        w0 = 16'($urandom);
        w1 = 16'($urandom);
        rx_log.delete();
        send(16'($urandom), 0);
        send(16'($urandom), 0);
        send(16'($urandom), 1);
        send(w0, 0);
        send(w1, 1);
        wait_idle(50);
        check("t5_n", rx_log.size(), 6);
        if (rx_log.size() == 6) begin
            check("t5_a_last", rx_log[3][12], 1);
            check("t5_b_first", rx_log[4], {1'b0, w0[15:4]});
            check("t5_b_last", rx_log[5], {1'b1, w0[3:0], w1[15:8]});
        end

        // 6: asynchronous reset with 20 bits buffered
        send(16'hABC1, 0);
        send(16'h23DE, 0);
        bus.rd_ready = 1'b0;
        #2;
        check("t6_cnt20", dbg_cnt, 20);
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_rst_vld", bus.rd_vld, 0);
        check("t6_rst_wr_ready", bus.wr_ready, 1);
        check("t6_rst_cnt", dbg_cnt, 0);
        @(posedge clock);
        #1;
        rst_n = 1'b1;
        rx_log.delete();
        bus.rd_ready = 1'b1;
        send(16'h9876, 0);
        send(16'h5432, 1);
        wait_idle(50);
        check("t6_n", rx_log.size(), 2);
        if (rx_log.size() == 2) begin
            check("t6_e0", rx_log[0], 13'h0987);
            check("t6_e1", rx_log[1], 13'h1654);
        end

        // 7: random packets with random rd_ready
        rand_rdy = 1;
        rx_log.delete();
        exp_elems = 0;
        for (int p = 0; p < 6; p++) begin
            len = $urandom_range(1, 6);
            exp_elems += (16 * len) / 12;
            for (int w = 0; w < len; w++) send(16'($urandom), w == len - 1);
        end
        wait_idle(400);
        rand_rdy = 0;
        check("t7_n", rx_log.size(), exp_elems);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
